// File: rtl/pe_net_interface_if.sv
// PE-side and switch-side valid/ready channels of one leaf network interface.
// The slave modport is the interface block's view; master is the environment's.
interface pe_net_interface_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 2
);
    logic [DataWidth-AddrWidth-1:0] i_pe_data;
    logic [AddrWidth-1:0]           i_pe_dest;
    logic                           i_pe_valid;
    logic                           o_pe_ready;

    logic [DataWidth-1:0]           o_data;
    logic                           o_data_valid;
    logic                           i_data_ready;

    logic [DataWidth-1:0]           i_data;
    logic                           i_data_valid;
    logic                           o_data_ready;

    logic [DataWidth-AddrWidth-1:0] o_pe_data;
    logic                           o_pe_valid;
    logic                           i_pe_ready;

    modport slave (
        input  i_pe_data, i_pe_dest, i_pe_valid, i_data_ready,
        input  i_data, i_data_valid, i_pe_ready,
        output o_pe_ready, o_data, o_data_valid,
        output o_data_ready, o_pe_data, o_pe_valid
    );

    modport master (
        output i_pe_data, i_pe_dest, i_pe_valid, i_data_ready,
        output i_data, i_data_valid, i_pe_ready,
        input  o_pe_ready, o_data, o_data_valid,
        input  o_data_ready, o_pe_data, o_pe_valid
    );
endinterface

// File: rtl/pe_net_interface.sv
// Leaf network interface: TX builds {dest, payload} flits into a show-ahead FIFO,
// RX keeps flits addressed to MyAddr and counts (saturating) the misrouted ones.
module pe_net_interface #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 2,
    parameter int MyAddr    = 0,
    parameter int Depth     = 4
) (
    input  logic                     i_sclk,
    input  logic                     i_reset,
    pe_net_interface_if.slave        bus,
    output logic [$clog2(Depth):0]   o_tx_level,
    output logic [$clog2(Depth):0]   o_rx_level,
    output logic [7:0]               o_drop_count
);
    localparam int PW   = $clog2(Depth);
    localparam int LW   = PW + 1;
    localparam int PldW = DataWidth - AddrWidth;
    localparam logic [LW-1:0]        FullLvl = LW'(Depth);
    localparam logic [AddrWidth-1:0] LocalAddr = AddrWidth'(MyAddr);

    logic [DataWidth-1:0] tx_mem_q [Depth];
    logic [PW-1:0]        tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [LW-1:0]        tx_level_q, tx_level_d;
    logic                 tx_push, tx_pop, tx_full, tx_empty;

    logic [PldW-1:0]      rx_mem_q [Depth];
    logic [PW-1:0]        rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [LW-1:0]        rx_level_q, rx_level_d;
    logic                 rx_accept, rx_match, rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]           drop_q, drop_d;

    // Ready/valid come only from the registered level, never from the far side's handshake.
    always_comb begin
        tx_full    = (tx_level_q == FullLvl);
        tx_empty   = (tx_level_q == '0);
        tx_push    = bus.i_pe_valid && !tx_full;
        tx_pop     = bus.i_data_ready && !tx_empty;
        tx_wptr_d  = tx_wptr_q + PW'(tx_push);
        tx_rptr_d  = tx_rptr_q + PW'(tx_pop);
        tx_level_d = tx_level_q + LW'(tx_push) - LW'(tx_pop);
    end

    always_ff @(posedge i_sclk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < Depth; i++) tx_mem_q[i] <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_level_q <= '0;
        end else begin
            if (tx_push) tx_mem_q[tx_wptr_q] <= {bus.i_pe_dest, bus.i_pe_data};
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_level_q <= tx_level_d;
        end
    end

    assign bus.o_pe_ready   = !tx_full;
    assign bus.o_data_valid = !tx_empty;
    assign bus.o_data       = tx_mem_q[tx_rptr_q];
    assign o_tx_level       = tx_level_q;

    // A flit accepted for another PE is consumed here and only bumps the drop counter.
    always_comb begin
        rx_full    = (rx_level_q == FullLvl);
        rx_empty   = (rx_level_q == '0);
        rx_accept  = bus.i_data_valid && !rx_full;
        rx_match   = (bus.i_data[DataWidth-1 -: AddrWidth] == LocalAddr);
        rx_push    = rx_accept && rx_match;
        rx_pop     = bus.i_pe_ready && !rx_empty;
        rx_wptr_d  = rx_wptr_q + PW'(rx_push);
        rx_rptr_d  = rx_rptr_q + PW'(rx_pop);
        rx_level_d = rx_level_q + LW'(rx_push) - LW'(rx_pop);
        drop_d     = drop_q;
        if (rx_accept && !rx_match && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge i_sclk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < Depth; i++) rx_mem_q[i] <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_level_q <= '0;
            drop_q     <= '0;
        end else begin
            if (rx_push) rx_mem_q[rx_wptr_q] <= bus.i_data[PldW-1:0];
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_level_q <= rx_level_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.o_data_ready = !rx_full;
    assign bus.o_pe_valid   = !rx_empty;
    assign bus.o_pe_data    = rx_mem_q[rx_rptr_q];
    assign o_rx_level       = rx_level_q;
    assign o_drop_count     = drop_q;
endmodule
